// File: rtl/ms_dual_master_pkg.sv
// rtl/ms_dual_master_pkg.sv - section encoding and defaults for the dual-output master
package ms_dual_master_types;

  typedef enum logic [1:0] {
    SEC_IDLE   = 2'd0,
    SEC_WRITE1 = 2'd1,
    SEC_WAIT   = 2'd2,
    SEC_WRITE2 = 2'd3
  } sections_e;

  localparam int DEFAULT_INIT_VAL = 1337;

endpackage

// File: rtl/ms_dual_master.sv
// rtl/ms_dual_master.sv - accepts one word, republishes it on out1 then, after GAP idle cycles,
// on out2 tagged with a running transaction count
module ms_dual_master
  import ms_dual_master_types::*;
#(
  parameter int WIDTH    = 32,
  parameter int GAP      = 2,
  parameter int INIT_VAL = DEFAULT_INIT_VAL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] b_in,
  input  logic             b_in_sync,
  output logic             b_in_notify,
  output logic [WIDTH-1:0] m_out1,
  output logic             m_out1_sync,
  output logic [WIDTH-1:0] m_out2,
  output logic             m_out2_sync,
  output logic [1:0]       section_o
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  sections_e        r_sec;
  logic [WIDTH-1:0] r_val;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_m1;
  logic [WIDTH-1:0] r_m2;
  logic [GW-1:0]    r_gap;

  sections_e w_sec_nxt;
  logic      w_ld1;
  logic      w_ld2;
  logic      w_gap_ld;
  logic      w_gap_dec;
  logic      w_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sec <= SEC_IDLE;
    end else begin
      r_sec <= w_sec_nxt;
    end
  end

  // Outputs depend on the section register only, so they follow reset immediately.
  always_comb begin
    w_sec_nxt   = r_sec;
    w_ld1       = 1'b0;
    w_ld2       = 1'b0;
    w_gap_ld    = 1'b0;
    w_gap_dec   = 1'b0;
    w_inc       = 1'b0;
    b_in_notify = 1'b0;
    m_out1_sync = 1'b0;
    m_out2_sync = 1'b0;
    case (r_sec)
      SEC_IDLE: begin
        b_in_notify = 1'b1;
        if (b_in_sync) begin
          w_ld1     = 1'b1;
          w_sec_nxt = SEC_WRITE1;
        end
      end
      SEC_WRITE1: begin
        m_out1_sync = 1'b1;
        if (GAP > 0) begin
          w_gap_ld  = 1'b1;
          w_sec_nxt = SEC_WAIT;
        end else begin
          w_ld2     = 1'b1;
          w_sec_nxt = SEC_WRITE2;
        end
      end
      SEC_WAIT: begin
        if (r_gap == '0) begin
          w_ld2     = 1'b1;
          w_sec_nxt = SEC_WRITE2;
        end else begin
          w_gap_dec = 1'b1;
        end
      end
      SEC_WRITE2: begin
        m_out2_sync = 1'b1;
        w_inc       = 1'b1;
        w_sec_nxt   = SEC_IDLE;
      end
      default: w_sec_nxt = SEC_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_val <= WIDTH'(INIT_VAL);
      r_cnt <= '0;
      r_m1  <= '0;
      r_m2  <= '0;
      r_gap <= '0;
    end else begin
      if (w_ld1) begin
        r_val <= b_in;
        r_m1  <= b_in;
      end
      // r_val already holds the accepted word by the time out2 is computed.
      if (w_ld2) r_m2 <= r_val + r_cnt;
      if (w_inc) r_cnt <= r_cnt + 1'b1;
      if (w_gap_ld) begin
        r_gap <= GW'(GAP - 1);
      end else if (w_gap_dec) begin
        r_gap <= r_gap - 1'b1;
      end
    end
  end

  assign m_out1    = r_m1;
  assign m_out2    = r_m2;
  assign section_o = r_sec;

endmodule
